mix_columns_iter: RTL

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

---
 rtl/mix_columns_iter_if.sv | 23 ++
 rtl/mix_columns_iter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mix_columns_iter_if.sv
// Handshake bundle for mix_columns_iter: input block with mode, output block, status.
interface mix_columns_iter_if #(
    parameter int unsigned LENGTH = 128
);
    logic [LENGTH-1:0] inpt;
    logic              mode;
    logic              inpt_valid;
    logic              inpt_ready;
    logic [LENGTH-1:0] oupt;
    logic              oupt_valid;
    logic              oupt_ready;
    logic              busy;

    modport master (
        output inpt, mode, inpt_valid, oupt_ready,
        input  inpt_ready, oupt, oupt_valid, busy
    );

    modport slave (
        input  inpt, mode, inpt_valid, oupt_ready,
        output inpt_ready, oupt, oupt_valid, busy
    );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns over an LENGTH-bit state,
// transforming COLS_PER_CYCLE columns in place per clock.
module mix_columns_iter #(
    parameter int unsigned BYTE           = 8,
    parameter int unsigned DWORD          = 32,
    parameter int unsigned LENGTH         = 128,
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input logic               clk,
    input logic               rst,
    mix_columns_iter_if.slave bus
);
    localparam int unsigned NCOL = LENGTH / DWORD;
    localparam int unsigned CW   = $clog2(NCOL) + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [LENGTH-1:0] st_q;
    logic [LENGTH-1:0] st_d;
    logic [CW-1:0]     cnt_q;
    logic              mode_q;
    logic              ready_q;
    logic              valid_q;
    logic              busy_q;
    logic              last_group;

    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
        return {b[BYTE-2:0], 1'b0} ^ (b[BYTE-1] ? BYTE'(8'h1b) : '0);
    endfunction

    // Inverse coefficients are composed from x2/x4/x8 so only xtime and XOR appear.
    function automatic logic [DWORD-1:0] mix_col(input logic [DWORD-1:0] w, input logic inv);
        logic [BYTE-1:0]  a  [4];
        logic [BYTE-1:0]  x2 [4];
        logic [BYTE-1:0]  x4 [4];
        logic [BYTE-1:0]  x8 [4];
        logic [BYTE-1:0]  r  [4];
        logic [DWORD-1:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[DWORD-1-i*BYTE -: BYTE];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (inv) begin
                r[i] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
            end else begin
                r[i] = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
            end
            o[DWORD-1-i*BYTE -: BYTE] = r[i];
        end
        return o;
    endfunction

    always_comb begin
        int unsigned idx;
        idx  = 0;
        st_d = st_q;
        for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
            idx = 32'(cnt_q) + g;
            if (idx < NCOL) begin
                st_d[idx*DWORD +: DWORD] = mix_col(st_q[idx*DWORD +: DWORD], mode_q);
            end
        end
    end

    assign last_group = (cnt_q == CW'(NCOL - COLS_PER_CYCLE));

    // ready_q starts low so inpt_ready only rises on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            st_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (ready_q && bus.inpt_valid) begin
                        st_q    <= bus.inpt;
                        mode_q  <= bus.mode;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    st_q  <= st_d;
                    cnt_q <= cnt_q + CW'(COLS_PER_CYCLE);
                    if (last_group) begin
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.oupt_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.inpt_ready = ready_q;
    assign bus.oupt_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.oupt       = st_q;
endmodule
